// File: rtl/crc32.sv
// ============================================================================
// Module      : crc32
// Description : Bit-serial CRC-32 engine. Computes (message * x^32) mod P over
//               GF(2) for one 32-bit word, MSB first, using a polynomial that
//               is captured at start. One message bit per clock, 32 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] message_i,
  input  logic        compute_i,
  input  logic [31:0] polynomial_i,
  output logic [31:0] message_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'd31;

  state_t      state;
  state_t      state_next;
  logic [4:0]  count;
  logic [31:0] msg;
  logic [31:0] crc;
  logic [31:0] poly;
  logic [31:0] crc_step;
  logic        feedback;
  logic        last_bit;

  // One LFSR step: the outgoing remainder bit mixed with the next message bit
  // decides whether the generator is subtracted (XORed) this cycle.
  always_comb begin
    feedback = crc[31] ^ msg[31];
    crc_step = {crc[30:0], 1'b0} ^ (feedback ? poly : 32'h0000_0000);
    last_bit = (count == LAST_BIT);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE waits for compute_i to drop so a held request
  // cannot retrigger the engine.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (compute_i) state_next = BUSY;
      BUSY:    if (last_bit)  state_next = DONE;
      DONE:    if (!compute_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on start, shift one bit per cycle while busy,
  // publish the final remainder on the edge that consumes bit 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count     <= 5'd0;
      msg       <= 32'h0000_0000;
      crc       <= 32'h0000_0000;
      poly      <= 32'h0000_0000;
      message_o <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (compute_i) begin
            msg   <= message_i;
            poly  <= polynomial_i;
            crc   <= 32'h0000_0000;
            count <= 5'd0;
          end
        end
        BUSY: begin
          crc   <= crc_step;
          msg   <= {msg[30:0], 1'b0};
          count <= count + 5'd1;
          if (last_bit) begin
            message_o <= crc_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_crc32.sv
// ============================================================================
// Module      : tb_crc32
// Description : Self-checking bench for crc32: fixed vectors, randomized words
//               against a polynomial long-division model, reset/abort, hold
//               and input-isolation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        compute_i = 1'b0;
  logic [31:0] message_i = 32'h0;
  logic [31:0] polynomial_i = 32'h0;
  logic [31:0] message_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] msg;
    logic [31:0] poly;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  crc32 dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .message_i    (message_i),
    .compute_i    (compute_i),
    .polynomial_i (polynomial_i),
    .message_o    (message_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: long division of m*x^32 by the full 33-bit generator x^32+P.
  function automatic logic [31:0] ref_crc(input logic [31:0] m, input logic [31:0] p);
    logic [63:0] v;
    logic [63:0] g;
    v = {m, 32'h0};
    g = {31'b0, 1'b1, p};
    for (int i = 63; i >= 32; i--) begin
      if (v[i]) v = v ^ (g << (i - 32));
    end
    return v[31:0];
  endfunction

  // Start an operation, verify message_o holds through edges E+1..E+31 and
  // carries the expected value after E+32. Optionally disturbs the inputs
  // and drops compute_i right after the capture edge.
  task automatic run_op(input logic [31:0] m, input logic [31:0] p, input logic [31:0] exp,
                        input string name, input bit disturb);
    logic [31:0] prev;
    bit          stable;
    @(negedge clk_i);
    message_i    = m;
    polynomial_i = p;
    compute_i    = 1'b1;
    prev         = message_o;
    @(posedge clk_i);
    @(negedge clk_i);
    if (disturb) begin
      message_i    = ~m;
      polynomial_i = p ^ 32'h5A5A_1234;
      compute_i    = 1'b0;
    end
    stable = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk_i);
      #1;
      if (message_o !== prev) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s_latency: message_o changed before edge E+32 (now %h, held %h)",
               name, message_o, prev);
    end
    @(posedge clk_i);
    #1;
    check(name, message_o, exp);
  endtask

  task automatic release_compute();
    @(negedge clk_i);
    compute_i = 1'b0;
    @(posedge clk_i);
  endtask

  initial begin
    logic [31:0] m;
    logic [31:0] p;
    logic [31:0] held;
    bit          stable;

    vecs[0] = '{32'h0000_0001, 32'h04C1_1DB7, 32'h04C1_1DB7};
    vecs[1] = '{32'h0000_0002, 32'h04C1_1DB7, 32'h0982_3B6E};
    vecs[2] = '{32'h0000_0000, 32'h04C1_1DB7, 32'h0000_0000};
    vecs[3] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
    vecs[5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    // Reset held with compute requested: nothing may start.
    message_i    = 32'h0000_0001;
    polynomial_i = 32'h04C1_1DB7;
    compute_i    = 1'b1;
    repeat (10) @(negedge clk_i);
    check("reset_hold", message_o, 32'h0);
    rst_i     = 1'b1;
    compute_i = 1'b0;
    repeat (40) @(negedge clk_i);
    check("reset_release", message_o, 32'h0);

    // Fixed vectors.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].msg, vecs[i].poly, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
      release_compute();
    end

    // Long hold in DONE: no restart even though message_i changes.
    run_op(32'hFFEE_FFEE, 32'h04C1_1DB7, ref_crc(32'hFFEE_FFEE, 32'h04C1_1DB7), "long", 1'b0);
    held   = message_o;
    stable = 1'b1;
    @(negedge clk_i);
    message_i = 32'h1234_5678;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (message_o !== held) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL done_hold: message_o %h required stable %h", message_o, held);
    end
    release_compute();
    run_op(32'h1234_5678, 32'h04C1_1DB7, ref_crc(32'h1234_5678, 32'h04C1_1DB7), "retrigger", 1'b0);
    release_compute();

    // Randomized words and polynomials against the division model.
    for (int i = 0; i < 8; i++) begin
      m = $urandom;
      p = (i < 4) ? 32'h04C1_1DB7 : 32'($urandom);
      run_op(m, p, ref_crc(m, p), $sformatf("rand%0d", i), 1'b0);
      release_compute();
    end

    // Input isolation: inputs change and compute drops right after capture.
    run_op(32'hCAFE_F00D, 32'h1EDC_6F41, ref_crc(32'hCAFE_F00D, 32'h1EDC_6F41), "isolation", 1'b1);
    @(posedge clk_i);

    // Asynchronous abort 10 cycles into BUSY.
    @(negedge clk_i);
    message_i    = 32'hA5A5_0F0F;
    polynomial_i = 32'h04C1_1DB7;
    compute_i    = 1'b1;
    @(posedge clk_i);
    repeat (10) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("abort_async", message_o, 32'h0);
    @(negedge clk_i);
    compute_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    run_op(32'hA5A5_0F0F, 32'h04C1_1DB7, ref_crc(32'hA5A5_0F0F, 32'h04C1_1DB7), "after_abort", 1'b0);
    release_compute();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
